crossing_scheduler: RTL and testbench
=====================================

# crossing_scheduler

Request scheduler placed in front of the pedestrian/cyclist crossing controller. It synchronises and debounces the pedestrian and cyclist push-buttons, latches pending requests, and drives the controller's `start` input with an acknowledged handshake. It tracks the returned 5-bit light sequence to detect crossing completion, then enforces a minimum vehicle-green gap before issuing the next crossing. It also reports wait lamps, served requesters, a crossing count and a handshake fault.

## Interface
Parameters:
- `DEBOUNCE`, 3: consecutive synchronised-high cycles that qualify a press (≥1).
- `MIN_GAP`, 8: vehicle-green cycles enforced after a crossing completes (≥1).
- `ACK_TIMEOUT`, 4: cycles `start` is held without acceptance before fault (≥2).

Ports:
- `clock`  in  1  single system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ped_btn`  in  1  raw pedestrian button, asynchronous.
- `cyc_btn`  in  1  raw cyclist button, asynchronous.
- `lightseq`  in  5  light sequence returned by the crossing controller.
- `start`  out  1  request to crossing controller, registered.
- `ped_wait`  out  1  pedestrian request pending.
- `cyc_wait`  out  1  cyclist request pending.
- `served`  out  2  {cyc,ped} requests served by the most recent crossing.
- `crossings`  out  8  accepted-crossing count, wraps 255→0.
- `busy`  out  1  high in ISSUE, ACTIVE and GAP.
- `fault`  out  1  sticky acknowledge-timeout flag.

## Operation
- Light codes: R__G=01001 (vehicles green), R__A=01010, G__R=10100 (walk), R_R_A=01110.
- Input path per button:
  - 2-flop synchroniser, then a saturating debounce counter.
  - Debounced level rises after `DEBOUNCE` consecutive synchronised-high cycles and falls on the first synchronised-low cycle.
  - Press event = one-cycle pulse on the debounced rising edge. A held button produces one event.
- Request latches `ped_wait`/`cyc_wait`:
  - Set by a press event, except in ISSUE and in ACTIVE before `saw_rra`. Those presses are ignored because the walk phase serves them.
  - Both latches are cleared on acceptance (ISSUE→ACTIVE). A press event in the acceptance cycle is also discarded.
- FSM states:
  - IDLE: `start`=0. Go to ISSUE when (`ped_wait`|`cyc_wait`) and gap counter == 0.
  - ISSUE: `start`=1 and timer counts. Acceptance (`lightseq` != R__G) → ACTIVE. On acceptance: `served` ← {cyc_wait,ped_wait}, `crossings` += 1, latches cleared, `saw_rra` cleared, `start`=0 from next cycle. If the timer reaches `ACK_TIMEOUT` with no acceptance → `fault`=1, IDLE, latches kept, so IDLE retries.
  - ACTIVE: set `saw_rra` when `lightseq`==R_R_A. When `lightseq`==R__G and `saw_rra` → GAP, gap counter ← `MIN_GAP`-1.
  - GAP: decrement each cycle; at 0 → IDLE. Presses latch normally.
- Gap counter reset value is 0, so the first request after reset issues without a gap.
- `fault` clears only on reset. Scheduling continues while `fault`=1.

## Timing
- Reset values: `start`=0, `ped_wait`=0, `cyc_wait`=0, `served`=00, `crossings`=0, `busy`=0, `fault`=0; FSM IDLE; debounce counters and synchronisers 0.
- Button to wait lamp: 2 sync cycles + `DEBOUNCE` + 1 latch cycle. Default = 6 clocks after the first sampled-high edge.
- Latch set in cycle N, IDLE with gap 0 → ISSUE and `start`=1 in N+1.
- The controller samples `start` at the end of N+1, so `lightseq`=R__A in N+2. Acceptance at the end of N+2; `start`=0, `busy` stays 1 from N+3.
- `start` is high for exactly 2 cycles in a normal handshake.
- Crossing completion: first R__G cycle after R_R_A. `busy` falls exactly `MIN_GAP` cycles later.
- Reset mid-operation clears all state immediately. The controller is reset by the same system reset.

## Test plan
- Reset with buttons low → all outputs 0, `start` never asserts over 50 cycles.
- `ped_btn` high 10 cycles → `ped_wait`=1 at the 6th edge. `start`=1 for 2 cycles. `served`=01, `crossings`=1, `ped_wait`=0 on acceptance. `busy` falls 8 cycles after R__G returns.
- `ped_btn` glitch high 2 cycles (`DEBOUNCE`=3) → no wait, no `start`.
- Both buttons pressed together → single crossing, `served`=11. `cyc_btn` re-pressed during G__R is ignored. Re-pressed after R_R_A → `cyc_wait`=1, next `start` only after the 8-cycle gap.
- `lightseq` forced to 01001 while requesting → `start` high 4 cycles, `fault`=1, retry follows. Releasing the force → acceptance, `fault` stays 1.
- 256 crossings → `crossings` wraps to 0. Reset asserted mid-ACTIVE → all outputs 0 at once.

Source files
------------

// File: rtl/crossing_scheduler_if.sv
// Start/acknowledge link between the request scheduler and the crossing controller.
// The scheduler raises start; the controller answers through its light sequence.
interface crossing_scheduler_if;
  logic       start;
  logic [4:0] lightseq;

  modport master (output start, input lightseq);
  modport slave  (input start, output lightseq);
endinterface

// File: rtl/crossing_scheduler.sv
// Debounces pedestrian/cyclist buttons, latches requests and hands crossings to the
// controller with an acknowledged start, enforcing a vehicle-green gap between crossings.
module crossing_scheduler #(
  parameter int DEBOUNCE    = 3,
  parameter int MIN_GAP     = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ped_btn,
  input  logic                 cyc_btn,
  crossing_scheduler_if.master ctl,
  output logic                 ped_wait,
  output logic                 cyc_wait,
  output logic [1:0]           served,
  output logic [7:0]           crossings,
  output logic                 busy,
  output logic                 fault
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [4:0] L_RG  = 5'b01001;
  localparam logic [4:0] L_RRA = 5'b01110;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE, S_GAP} state_t;

  // Index 0 = pedestrian, index 1 = cyclist
  logic [1:0]    w_btn;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_lvl_q;
  logic [DW-1:0] r_deb_cnt [2];
  logic [1:0]    w_lvl;
  logic [1:0]    w_press;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_start;
  logic [TW-1:0] r_timer;
  logic [GW-1:0] r_gap;
  logic          r_saw_rra;
  logic          r_ped_wait;
  logic          r_cyc_wait;
  logic [1:0]    r_served;
  logic [7:0]    r_crossings;
  logic          r_fault;

  logic          w_req;
  logic          w_accept;
  logic          w_timeout;
  logic          w_done;
  logic          w_press_ok;

  assign w_btn = {cyc_btn, ped_btn};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_lvl_q      <= '0;
      r_deb_cnt[0] <= '0;
      r_deb_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_lvl_q <= w_lvl;
      for (int i = 0; i < 2; i++) begin
        if (!r_sync2[i])
          r_deb_cnt[i] <= '0;
        else if (r_deb_cnt[i] != DW'(DEBOUNCE))
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
      end
    end
  end

  // Saturated counter is the debounced level; its rising edge is the single press event
  always_comb begin
    w_lvl = '0;
    for (int i = 0; i < 2; i++)
      w_lvl[i] = (r_deb_cnt[i] == DW'(DEBOUNCE));
    w_press = w_lvl & ~r_lvl_q;
  end

  assign w_req      = r_ped_wait | r_cyc_wait;
  assign w_accept   = (r_state == S_ISSUE) && (ctl.lightseq != L_RG);
  assign w_timeout  = (r_state == S_ISSUE) && !w_accept && (r_timer == TW'(ACK_TIMEOUT - 1));
  assign w_done     = (r_state == S_ACTIVE) && r_saw_rra && (ctl.lightseq == L_RG);
  // Presses before the all-red phase would be served by the walk already in progress
  assign w_press_ok = (r_state != S_ISSUE) && !((r_state == S_ACTIVE) && !r_saw_rra);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req && (r_gap == '0)) w_state_nxt = S_ISSUE;
      S_ISSUE:  if (w_accept)               w_state_nxt = S_ACTIVE;
                else if (w_timeout)         w_state_nxt = S_IDLE;
      S_ACTIVE: if (w_done)                 w_state_nxt = S_GAP;
      S_GAP:    if (r_gap == '0)            w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_timer     <= '0;
      r_gap       <= '0;
      r_saw_rra   <= 1'b0;
      r_ped_wait  <= 1'b0;
      r_cyc_wait  <= 1'b0;
      r_served    <= '0;
      r_crossings <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= (w_state_nxt == S_ISSUE);
      r_timer <= (r_state == S_ISSUE) ? r_timer + 1'b1 : '0;

      if (w_done)
        r_gap <= GW'(MIN_GAP - 1);
      else if ((r_state == S_GAP) && (r_gap != '0))
        r_gap <= r_gap - 1'b1;

      if (w_accept)
        r_saw_rra <= 1'b0;
      else if ((r_state == S_ACTIVE) && (ctl.lightseq == L_RRA))
        r_saw_rra <= 1'b1;

      if (w_accept) begin
        r_ped_wait  <= 1'b0;
        r_cyc_wait  <= 1'b0;
        r_served    <= {r_cyc_wait, r_ped_wait};
        r_crossings <= r_crossings + 8'd1;
      end else begin
        if (w_press[0] && w_press_ok) r_ped_wait <= 1'b1;
        if (w_press[1] && w_press_ok) r_cyc_wait <= 1'b1;
      end

      if (w_timeout)
        r_fault <= 1'b1;
    end
  end

  assign ctl.start = r_start;
  assign ped_wait  = r_ped_wait;
  assign cyc_wait  = r_cyc_wait;
  assign served    = r_served;
  assign crossings = r_crossings;
  assign busy      = (r_state != S_IDLE);
  assign fault     = r_fault;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Bench for crossing_scheduler: a simple crossing-controller model answers start,
// a scoreboard checks every accepted crossing, vectors and sequences cover the corners.
module tb_crossing_scheduler;

  localparam int MIN_GAP     = 8;
  localparam int ACK_TIMEOUT = 4;

  localparam logic [4:0] RG  = 5'b01001;
  localparam logic [4:0] RA  = 5'b01010;
  localparam logic [4:0] GR  = 5'b10100;
  localparam logic [4:0] RRA = 5'b01110;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ped_btn = 1'b0;
  logic       cyc_btn = 1'b0;
  logic       ped_wait, cyc_wait, busy, fault;
  logic [1:0] served;
  logic [7:0] crossings;

  crossing_scheduler_if ifc();

  crossing_scheduler #(
    .DEBOUNCE(3), .MIN_GAP(MIN_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .ped_btn(ped_btn), .cyc_btn(cyc_btn), .ctl(ifc),
    .ped_wait(ped_wait), .cyc_wait(cyc_wait), .served(served),
    .crossings(crossings), .busy(busy), .fault(fault)
  );

  always #5 clock = ~clock;

  // Controller model: R__A x2, G__R x10, R_R_A x2, then back to R__G
  int   ph;
  bit   force_rg = 1'b0;
  logic [4:0] ls;

  always @(posedge clock or negedge reset) begin
    if (!reset)          ph <= 0;
    else if (force_rg)   ph <= 0;
    else if (ph == 0)    begin if (ifc.start) ph <= 1; end
    else if (ph == 14)   ph <= 0;
    else                 ph <= ph + 1;
  end

  always_comb begin
    ls = RG;
    if (!force_rg && ph != 0)
      ls = (ph <= 2) ? RA : (ph <= 12) ? GR : RRA;
  end
  assign ifc.lightseq = ls;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [1:0] served; logic [7:0] cnt; } exp_t;
  exp_t       sb_q[$];
  logic [7:0] exp_cross = 8'd0;
  logic [7:0] prev_cnt  = 8'd0;

  task automatic push_exp(input logic [1:0] s);
    exp_cross = exp_cross + 8'd1;
    sb_q.push_back('{s, exp_cross});
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) prev_cnt = 8'd0;
    else if (crossings != prev_cnt) begin
      if (sb_q.size() == 0) chk("sb_unexpected_crossing", crossings, prev_cnt);
      else begin
        e = sb_q.pop_front();
        chk("sb_served", served, e.served);
        chk("sb_crossings", crossings, e.cnt);
      end
      prev_cnt = crossings;
    end
  end

  task automatic check_zero(input string p);
    chk({p, "_start"},     ifc.start, 0);
    chk({p, "_ped_wait"},  ped_wait,  0);
    chk({p, "_cyc_wait"},  cyc_wait,  0);
    chk({p, "_served"},    served,    0);
    chk({p, "_crossings"}, crossings, 0);
    chk({p, "_busy"},      busy,      0);
    chk({p, "_fault"},     fault,     0);
  endtask

  task automatic wait_ls(input logic [4:0] v, input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clock);
      if (ifc.lightseq == v) break;
    end
    if (k == 60) chk({nm, "_timeout"}, ifc.lightseq, v);
  endtask

  task automatic wait_busy(input logic want, input string nm);
    int k;
    for (k = 0; k < 80; k++) begin
      if (busy == want) break;
      @(negedge clock);
    end
    if (k == 80) chk({nm, "_timeout"}, busy, want);
  endtask

  typedef struct { int ped_len; int cyc_len; bit exp_ped; bit exp_cyc; } vec_t;
  vec_t vecs[6];

  initial begin
    int   hi, first;
    logic seen_p, seen_c, seen_s;

    vecs[0] = '{10, 0,  1'b1, 1'b0};
    vecs[1] = '{2,  0,  1'b0, 1'b0};
    vecs[2] = '{0,  10, 1'b0, 1'b1};
    vecs[3] = '{10, 10, 1'b1, 1'b1};
    vecs[4] = '{4,  0,  1'b1, 1'b0};
    vecs[5] = '{0,  2,  1'b0, 1'b0};

    // Reset with buttons low, then 50 quiet cycles
    repeat (3) @(negedge clock);
    check_zero("in_reset");
    reset = 1'b1;
    seen_s = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      seen_s |= ifc.start;
    end
    chk("quiet_no_start", seen_s, 0);
    check_zero("quiet");

    // Button-pattern vectors
    for (int i = 0; i < 6; i++) begin
      seen_p = 0; seen_c = 0; seen_s = 0;
      if (vecs[i].exp_ped || vecs[i].exp_cyc) push_exp({vecs[i].exp_cyc, vecs[i].exp_ped});
      for (int c = 0; c < 40; c++) begin
        ped_btn = (c < vecs[i].ped_len);
        cyc_btn = (c < vecs[i].cyc_len);
        @(negedge clock);
        seen_p |= ped_wait;
        seen_c |= cyc_wait;
        seen_s |= ifc.start;
      end
      ped_btn = 0; cyc_btn = 0;
      wait_busy(1'b0, "vec_idle");
      chk($sformatf("vec%0d_ped_wait", i), seen_p, vecs[i].exp_ped);
      chk($sformatf("vec%0d_cyc_wait", i), seen_c, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_start", i), seen_s, vecs[i].exp_ped | vecs[i].exp_cyc);
    end

    // Latency: lamp at 6th edge, start for exactly 2 cycles, gap of MIN_GAP
    push_exp(2'b01);
    ped_btn = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 5) chk("lamp_before_edge6", ped_wait, 0);
      if (k == 6) begin chk("lamp_at_edge6", ped_wait, 1); chk("start_in_latch_cycle", ifc.start, 0); end
      if (k == 7 || k == 8) chk($sformatf("start_high_k%0d", k), ifc.start, 1);
      if (k == 9) begin
        chk("start_low_after_ack", ifc.start, 0);
        chk("busy_after_ack", busy, 1);
        chk("ped_wait_cleared", ped_wait, 0);
        chk("served_ped", served, 2'b01);
      end
    end
    ped_btn = 0;
    wait_ls(RRA, "lat_rra");
    wait_ls(RG, "lat_rg");
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (busy) hi++; else break;
    end
    chk("gap_length", hi, MIN_GAP);

    // Both buttons, re-press in walk ignored, re-press after all-red latched
    push_exp(2'b11);
    ped_btn = 1; cyc_btn = 1;
    repeat (8) @(negedge clock);
    ped_btn = 0; cyc_btn = 0;
    wait_ls(GR, "both_gr");
    cyc_btn = 1;
    seen_c = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 5) cyc_btn = 0;
      seen_c |= cyc_wait;
      if (ifc.lightseq == RRA) break;
    end
    chk("cyc_ignored_in_walk", seen_c, 0);
    push_exp(2'b10);
    @(negedge clock);
    cyc_btn = 1;
    @(negedge clock);
    chk("completion_rg", ifc.lightseq, RG);
    first = -1; seen_c = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (k == 6) cyc_btn = 0;
      seen_c |= cyc_wait;
      if (ifc.start && first < 0) first = k;
    end
    chk("cyc_latched_after_rra", seen_c, 1);
    chk("next_start_after_gap", first, MIN_GAP + 2);
    wait_busy(1'b0, "both_idle");

    // Acknowledge timeout, retry, then acceptance with fault sticky
    force_rg = 1;
    push_exp(2'b01);
    ped_btn = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (ifc.start) break;
    end
    ped_btn = 0;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (ifc.start) hi++; else break;
      @(negedge clock);
    end
    chk("timeout_start_len", hi, ACK_TIMEOUT);
    chk("fault_set", fault, 1);
    chk("wait_kept_on_fault", ped_wait, 1);
    chk("idle_after_fault", busy, 0);
    @(negedge clock);
    chk("retry_start", ifc.start, 1);
    force_rg = 0;
    @(negedge clock);
    @(negedge clock);
    chk("retry_accepted_start", ifc.start, 0);
    chk("retry_accepted_busy", busy, 1);
    chk("fault_sticky", fault, 1);
    wait_busy(1'b0, "fault_idle");
    chk("fault_sticky_idle", fault, 1);

    // Reset asserted mid-ACTIVE clears everything immediately
    push_exp(2'b01);
    ped_btn = 1;
    repeat (4) @(negedge clock);
    ped_btn = 0;
    wait_ls(GR, "mid_gr");
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1 check_zero("mid_reset");
    chk("mid_reset_ls", ifc.lightseq, RG);
    repeat (2) @(negedge clock);
    sb_q.delete();
    exp_cross = 8'd0;
    reset = 1'b1;

    // 256 crossings wrap the counter
    for (int n = 0; n < 256; n++) begin
      push_exp(2'b01);
      ped_btn = 1;
      repeat (4) @(negedge clock);
      ped_btn = 0;
      wait_busy(1'b1, "wrap_go");
      wait_busy(1'b0, "wrap_end");
    end
    chk("wrap_crossings", crossings, 0);
    chk("wrap_fault_clear", fault, 0);
    repeat (2) @(negedge clock);
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
